cpu_bus_fabric: RTL
===================

Name: cpu_bus_fabric

Overview:
Parametrised CPU-bus interconnect between the CPU wrapper and N peripheral devices. It replaces the fixed per-ID bus fan-out with registered address decode, one-outstanding-transaction tracking, a per-access watchdog timeout and error responses for unmapped or unresponsive devices. Sticky diagnostic status (error count, last faulting address, overrun and stray-ack flags) is exported for the CPU config block.

Parameters:
NUM_DEVICES, 12, number of device slots; valid IDs are 0..NUM_DEVICES-1.
ID_LSB, 24, lowest address bit of the device ID field.
ID_WIDTH, 4, width of the device ID field; 2**ID_WIDTH >= NUM_DEVICES.
TIMEOUT_CYCLES, 255, maximum WAIT cycles before an error ack; 0 disables the timeout.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_request  in  1  single-cycle access request pulse
cpu_address  in  32  byte address
cpu_wmask  in  4  byte write mask; 0 means read
cpu_wdata  in  32  write data
cpu_ack  out  1  single-cycle completion pulse
cpu_error  out  1  valid with cpu_ack; 1 means unmapped or timeout
cpu_rdata  out  32  read data, valid with cpu_ack
busy  out  1  transaction outstanding
dev_request  out  NUM_DEVICES  one-hot single-cycle request pulse
dev_address  out  32  registered address, shared by all devices
dev_wmask  out  4  registered write mask, shared
dev_wdata  out  32  registered write data, shared
dev_ack  in  NUM_DEVICES  per-device single-cycle ack
dev_rdata  in  NUM_DEVICES*32  per-device read data; slot i is bits [32i+31:32i]
err_clear  in  1  pulse that clears all sticky status
err_count  out  ERR_CNT_WIDTH  saturating count of error acks
err_address  out  32  address of the most recent error ack
err_overrun  out  1  sticky: cpu_request seen while busy
err_stray  out  1  sticky: dev_ack from an unselected device or while idle

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latched address, mask, data and device ID are 0.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE, cpu_request=1 at cycle T:
  - Latch address, wmask and wdata; decode id = cpu_address[ID_LSB+ID_WIDTH-1:ID_LSB].
  - If id < NUM_DEVICES: dev_request[id]=1 at T+1 only, dev_* buses hold the latched values, go to WAIT.
  - Otherwise (unmapped): no dev_request; go to RESPOND, which issues cpu_ack=1, cpu_error=1, cpu_rdata=0 at T+1.
- WAIT:
  - A wait counter starts at 0 on the cycle dev_request is high and increments each cycle.
  - dev_ack[id]=1 at cycle D: cpu_ack=1, cpu_error=0 at D+1. cpu_rdata = the registered dev_rdata slot id; it is 32'h0 for writes.
  - dev_ack may arrive in the same cycle as dev_request; cpu_ack follows at T+2.
  - Timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with no ack, cpu_ack=1, cpu_error=1, cpu_rdata=0 on the next cycle.
  - If ack and timeout expiry occur in the same cycle, the ack wins.
- RESPOND lasts exactly one cycle, then returns to IDLE. busy=1 from T+1 through the cpu_ack cycle inclusive. A new request is accepted on the cycle after cpu_ack.
- cpu_ack, cpu_error and dev_request are pulses; cpu_rdata holds its value until the next cpu_ack.
- A dev_ack from the selected device arriving after a timeout error counts as stray and is ignored.
- A cpu_request while busy=1 is dropped: no forwarding, no ack, err_overrun set.
- Any dev_ack bit in IDLE or RESPOND, or from a non-selected device in WAIT, sets err_stray and is otherwise ignored.
- Each error ack increments err_count, saturating at all-ones, and loads err_address with the latched address.
- err_clear zeroes err_count, err_address, err_overrun and err_stray. If err_clear coincides with a new error event, the event wins: count=1, address and flags loaded.
- Counter width is clog2(TIMEOUT_CYCLES+1). No wrap occurs because the counter stops at TIMEOUT_CYCLES.
- reset_n low mid-transaction: immediate return to IDLE, outputs 0, no cpu_ack for the aborted access.

Test Plan:
- Read, ID 3, address 0x0300_0010, dev_ack[3] 2 cycles after dev_request with rdata 0xCAFE_F00D -> dev_request=0x008 at T+1; cpu_ack, cpu_error=0, cpu_rdata=0xCAFE_F00D at T+4.
- Write to address 0x0F00_0000 (ID 15 >= 12) -> no dev_request; cpu_ack, cpu_error=1, rdata=0 at T+1; err_count=1, err_address=0x0F00_0000.
- TIMEOUT_CYCLES=4, ID 2, no dev_ack -> cpu_ack with error exactly 5 cycles after dev_request; a late dev_ack[2] sets err_stray with no second cpu_ack.
- dev_ack[5] on the same cycle the counter hits TIMEOUT_CYCLES -> cpu_error=0, rdata forwarded, err_count unchanged.
- Second cpu_request while busy, then 260 unmapped accesses with ERR_CNT_WIDTH=8 -> err_overrun=1, err_count saturates at 255; err_clear -> all status 0.
- reset_n asserted during WAIT -> busy, dev_request and cpu_ack 0; the next access after release completes normally.

Source files
------------

// File: rtl/cpu_bus_fabric.sv
// cpu_bus_fabric: interconnect between the CPU wrapper and NUM_DEVICES
// peripheral slots. It accepts one access at a time, decodes the device ID
// from the address, forwards a one-hot request pulse and waits for that
// device's ack. A watchdog ends the access with an error ack. Unmapped IDs
// also produce an error ack. Sticky status is kept for the config block.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   cpu_request/address/wmask/wdata  access request (wmask==0 is a read)
//   cpu_ack/error/rdata           completion pulse, error flag, read data
//   busy                          an access is outstanding
//   dev_request                   one-hot request pulse per device
//   dev_address/wmask/wdata       latched request, shared by all devices
//   dev_ack, dev_rdata            per-device ack pulse and 32-bit read data
//   err_clear                     clears all sticky status
//   err_count/address/overrun/stray  sticky diagnostic status
module cpu_bus_fabric #(
  parameter int NUM_DEVICES    = 12,
  parameter int ID_LSB         = 24,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_request,
  input  logic [31:0]               cpu_address,
  input  logic [3:0]                cpu_wmask,
  input  logic [31:0]               cpu_wdata,
  output logic                      cpu_ack,
  output logic                      cpu_error,
  output logic [31:0]               cpu_rdata,
  output logic                      busy,
  output logic [NUM_DEVICES-1:0]    dev_request,
  output logic [31:0]               dev_address,
  output logic [3:0]                dev_wmask,
  output logic [31:0]               dev_wdata,
  input  logic [NUM_DEVICES-1:0]    dev_ack,
  input  logic [NUM_DEVICES*32-1:0] dev_rdata,
  input  logic                      err_clear,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [31:0]               err_address,
  output logic                      err_overrun,
  output logic                      err_stray
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  state_e                   state_q;
  logic [31:0]              addr_q, wdata_q, rdata_q;
  logic [3:0]               wmask_q;
  logic [ID_WIDTH-1:0]      id_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ack_q, err_q, busy_q;
  logic [NUM_DEVICES-1:0]   dreq_q;

  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]              err_addr_q, err_addr_d;
  logic                     overrun_q, overrun_d, stray_q, stray_d;

  logic [ID_WIDTH-1:0]      req_id;
  logic [NUM_DEVICES-1:0]   req_onehot, sel_onehot;
  logic                     req_mapped, sel_ack, timeout_hit;
  logic [31:0]              sel_rdata;
  logic                     err_evt, stray_evt, overrun_evt;

  // Decode: IDs with no matching slot leave the one-hot empty, which is
  // exactly the unmapped case.
  always_comb begin
    req_id     = cpu_address[ID_LSB +: ID_WIDTH];
    req_onehot = '0;
    sel_onehot = '0;
    sel_rdata  = '0;
    for (int unsigned i = 0; i < NUM_DEVICES; i++) begin
      if (req_id == ID_WIDTH'(i)) req_onehot[i] = 1'b1;
      if (id_q == ID_WIDTH'(i)) begin
        sel_onehot[i] = 1'b1;
        sel_rdata     = dev_rdata[32*i +: 32];
      end
    end
    req_mapped  = |req_onehot;
    sel_ack     = |(dev_ack & sel_onehot);
    timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  end

  // Sticky status events; an event in the same cycle as err_clear wins.
  always_comb begin
    overrun_evt = cpu_request && busy_q;
    stray_evt   = (state_q == WAIT) ? |(dev_ack & ~sel_onehot) : |dev_ack;
    err_evt     = ((state_q == IDLE) && cpu_request && !req_mapped) ||
                  ((state_q == WAIT) && !sel_ack && timeout_hit);

    err_cnt_d  = err_clear ? '0 : err_cnt_q;
    err_addr_d = err_clear ? '0 : err_addr_q;
    if (err_evt) begin
      // An unmapped error is raised while the address is being latched.
      err_addr_d = (state_q == IDLE) ? cpu_address : addr_q;
      if (err_clear)
        err_cnt_d = ERR_CNT_WIDTH'(1);
      else if (err_cnt_q != '1)
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end
    overrun_d = (overrun_q && !err_clear) || overrun_evt;
    stray_d   = (stray_q && !err_clear) || stray_evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      dreq_q  <= '0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dreq_q <= '0;
      case (state_q)
        IDLE: begin
          if (cpu_request) begin
            addr_q  <= cpu_address;
            wmask_q <= cpu_wmask;
            wdata_q <= cpu_wdata;
            id_q    <= req_id;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (req_mapped) begin
              dreq_q  <= req_onehot;
              state_q <= WAIT;
            end else begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= RESPOND;
            end
          end
        end
        WAIT: begin
          if (sel_ack) begin
            ack_q   <= 1'b1;
            rdata_q <= (wmask_q == '0) ? sel_rdata : '0;
            state_q <= RESPOND;
          end else if (timeout_hit) begin
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= RESPOND;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESPOND: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      overrun_q  <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      overrun_q  <= overrun_d;
      stray_q    <= stray_d;
    end
  end

  assign cpu_ack     = ack_q;
  assign cpu_error   = err_q;
  assign cpu_rdata   = rdata_q;
  assign busy        = busy_q;
  assign dev_request = dreq_q;
  assign dev_address = addr_q;
  assign dev_wmask   = wmask_q;
  assign dev_wdata   = wdata_q;
  assign err_count   = err_cnt_q;
  assign err_address = err_addr_q;
  assign err_overrun = overrun_q;
  assign err_stray   = stray_q;

endmodule
